alu_op_sequencer: RTL and testbench

- Sequences one ALU operation for the 8-bit relay ALU: ADD, INC, AND, OR, XOR, NOT, SHL.
- Raises the selected function-enable line and holds it for a relay settle window.
- Pulses a destination load (A or D) and captures condition codes, then holds the enable for a relay hold window before release.
- Sits between the instruction controller and the ALU function units; only one enable line is high at any time.

---
 rtl/alu_op_sequencer_if.sv | 41 ++++
 rtl/alu_op_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bus between the instruction controller, the relay ALU function units and
// the ALU operation sequencer.
//   Controller side : start, func, dest -> sequencer; busy, done <- sequencer
//   ALU side        : alu_result, alu_carry -> sequencer;
//                     en_*, ld_a, ld_d, result, cc_* <- sequencer
//   slave  modport  : sequencer view
//   master modport  : controller / ALU view
interface alu_op_sequencer_if;
  logic       start;
  logic [2:0] func;
  logic       dest;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       en_add;
  logic       en_inc;
  logic       en_and;
  logic       en_or;
  logic       en_xor;
  logic       en_not;
  logic       en_shl;
  logic       ld_a;
  logic       ld_d;
  logic [7:0] result;
  logic       cc_z;
  logic       cc_s;
  logic       cc_c;
  logic       busy;
  logic       done;

  modport slave (
    input  start, func, dest, alu_result, alu_carry,
    output en_add, en_inc, en_and, en_or, en_xor, en_not, en_shl,
    output ld_a, ld_d, result, cc_z, cc_s, cc_c, busy, done
  );

  modport master (
    output start, func, dest, alu_result, alu_carry,
    input  en_add, en_inc, en_and, en_or, en_xor, en_not, en_shl,
    input  ld_a, ld_d, result, cc_z, cc_s, cc_c, busy, done
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences a single relay-ALU operation: raises one function enable, holds
// it through a settle window, strobes the destination load while capturing
// result and condition codes, holds the enable for a release window, then
// pulses done. func = 111 is a NOP that completes in one cycle.
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : alu_op_sequencer_if.slave (request, ALU bus, enables, loads,
//            result, flags, busy, done) -- all outputs are registered
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 3,  // 1..15
  parameter int unsigned HOLD_CYCLES   = 1   // 0..15, 0 skips HOLD
) (
  input  logic              clk,
  input  logic              reset,
  alu_op_sequencer_if.slave bus
);

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned EN_W        = 7;
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_INIT   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [2:0] FUNC_ADD = 3'b000;
  localparam logic [2:0] FUNC_INC = 3'b001;
  localparam logic [2:0] FUNC_NOP = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_LOAD   = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        func_q, func_d;
  logic              dest_q, dest_d;
  logic [EN_W-1:0]   en_q, en_d;
  logic              ld_a_q, ld_a_d;
  logic              ld_d_q, ld_d_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        result_q, result_d;
  logic              cc_z_q, cc_z_d;
  logic              cc_s_q, cc_s_d;
  logic              cc_c_q, cc_c_d;
  logic              active_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      func_q   <= '0;
      dest_q   <= 1'b0;
      en_q     <= '0;
      ld_a_q   <= 1'b0;
      ld_d_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cc_z_q   <= 1'b0;
      cc_s_q   <= 1'b0;
      cc_c_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func_q   <= func_d;
      dest_q   <= dest_d;
      en_q     <= en_d;
      ld_a_q   <= ld_a_d;
      ld_d_q   <= ld_d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cc_z_q   <= cc_z_d;
      cc_s_q   <= cc_s_d;
      cc_c_q   <= cc_c_d;
    end
  end

  // Next state, counter, flag capture and next registered outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    func_d   = func_q;
    dest_d   = dest_q;
    result_d = result_q;
    cc_z_d   = cc_z_q;
    cc_s_d   = cc_s_q;
    cc_c_d   = cc_c_q;
    en_d     = '0;
    ld_a_d   = 1'b0;
    ld_d_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    active_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.func == FUNC_NOP) begin
            state_d = S_DONE;
          end else begin
            func_d  = bus.func;
            dest_d  = bus.dest;
            cnt_d   = SETTLE_INIT;
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_LOAD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_LOAD: begin
        result_d = bus.alu_result;
        cc_z_d   = (bus.alu_result == 8'h00);
        cc_s_d   = bus.alu_result[7];
        cc_c_d   = ((func_q == FUNC_ADD) || (func_q == FUNC_INC)) ? bus.alu_carry : 1'b0;
        if (HOLD_CYCLES == 0) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = HOLD_INIT;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered.
    // func_d is the latched function once an operation is under way.
    active_d = (state_d == S_SETTLE) || (state_d == S_LOAD) || (state_d == S_HOLD);
    if (active_d && (func_d != FUNC_NOP)) en_d = EN_W'(1) << func_d;
    ld_a_d = (state_d == S_LOAD) && !dest_d;
    ld_d_d = (state_d == S_LOAD) &&  dest_d;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign bus.en_add = en_q[0];
  assign bus.en_inc = en_q[1];
  assign bus.en_and = en_q[2];
  assign bus.en_or  = en_q[3];
  assign bus.en_xor = en_q[4];
  assign bus.en_not = en_q[5];
  assign bus.en_shl = en_q[6];
  assign bus.ld_a   = ld_a_q;
  assign bus.ld_d   = ld_d_q;
  assign bus.result = result_q;
  assign bus.cc_z   = cc_z_q;
  assign bus.cc_s   = cc_s_q;
  assign bus.cc_c   = cc_c_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: default instance (SETTLE=3, HOLD=1)
// and a short instance (SETTLE=1, HOLD=0), checked cycle by cycle.
module tb_alu_op_sequencer;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  alu_op_sequencer_if bus0 ();
  alu_op_sequencer_if bus1 ();

  alu_op_sequencer dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  alu_op_sequencer #(
    .SETTLE_CYCLES (1),
    .HOLD_CYCLES   (0)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int dut, input logic st, input logic [2:0] f,
                       input logic d, input logic [7:0] r, input logic c);
    if (dut == 0) begin
      bus0.start = st; bus0.func = f; bus0.dest = d;
      bus0.alu_result = r; bus0.alu_carry = c;
    end else begin
      bus1.start = st; bus1.func = f; bus1.dest = d;
      bus1.alu_result = r; bus1.alu_carry = c;
    end
  endtask

  task automatic sample(input int dut, output logic [6:0] en, output logic la,
                        output logic ldd, output logic bsy, output logic dn,
                        output logic [7:0] res, output logic [2:0] zsc);
    if (dut == 0) begin
      en  = {bus0.en_shl, bus0.en_not, bus0.en_xor, bus0.en_or,
             bus0.en_and, bus0.en_inc, bus0.en_add};
      la  = bus0.ld_a; ldd = bus0.ld_d; bsy = bus0.busy; dn = bus0.done;
      res = bus0.result; zsc = {bus0.cc_z, bus0.cc_s, bus0.cc_c};
    end else begin
      en  = {bus1.en_shl, bus1.en_not, bus1.en_xor, bus1.en_or,
             bus1.en_and, bus1.en_inc, bus1.en_add};
      la  = bus1.ld_a; ldd = bus1.ld_d; bsy = bus1.busy; dn = bus1.done;
      res = bus1.result; zsc = {bus1.cc_z, bus1.cc_s, bus1.cc_c};
    end
  endtask

  function automatic logic [6:0] en_of(input logic [2:0] f);
    case (f)
      3'd0:    return 7'b0000001;
      3'd1:    return 7'b0000010;
      3'd2:    return 7'b0000100;
      3'd3:    return 7'b0001000;
      3'd4:    return 7'b0010000;
      3'd5:    return 7'b0100000;
      3'd6:    return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  // One operation from start to idle. LOAD is cycle s+1, HOLD s+2..s+h+1,
  // DONE s+h+2, back in IDLE at s+h+3. Flags are checked at the end.
  task automatic run_op(input string nm, input int dut, input logic [2:0] f,
                        input logic d, input logic [7:0] r, input logic c,
                        input int s, input int h, input logic keep_start,
                        input logic [7:0] exp_res, input logic [2:0] exp_zsc);
    logic [6:0] en;
    logic       la, ldd, bsy, dn;
    logic [7:0] res;
    logic [2:0] zsc;
    drive(dut, 1'b1, f, d, r, c);
    tick();
    if (!keep_start) drive(dut, 1'b0, f, d, r, c);
    for (int cyc = 1; cyc <= s + h + 3; cyc++) begin
      sample(dut, en, la, ldd, bsy, dn, res, zsc);
      chk($sformatf("%s en c%0d", nm, cyc), 32'(en),
          (cyc <= s + h + 1) ? 32'(en_of(f)) : 32'h0);
      chk($sformatf("%s ld_a c%0d", nm, cyc), 32'(la), 32'(cyc == s + 1 && !d));
      chk($sformatf("%s ld_d c%0d", nm, cyc), 32'(ldd), 32'(cyc == s + 1 && d));
      chk($sformatf("%s busy c%0d", nm, cyc), 32'(bsy), 32'(cyc <= s + h + 2));
      chk($sformatf("%s done c%0d", nm, cyc), 32'(dn), 32'(cyc == s + h + 2));
      tick();
    end
    if (!keep_start) begin
      sample(dut, en, la, ldd, bsy, dn, res, zsc);
      chk({nm, " result"}, 32'(res), 32'(exp_res));
      chk({nm, " zsc"}, 32'(zsc), 32'(exp_zsc));
    end
  endtask

  initial begin
    logic [6:0] en;
    logic       la, ldd, bsy, dn;
    logic [7:0] res;
    logic [2:0] zsc;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    drive(0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();

    // Reset values
    sample(0, en, la, ldd, bsy, dn, res, zsc);
    chk("rst en", 32'(en), 32'h0);
    chk("rst ld", 32'({la, ldd}), 32'h0);
    chk("rst busy/done", 32'({bsy, dn}), 32'h0);
    chk("rst result", 32'(res), 32'h0);
    chk("rst zsc", 32'(zsc), 32'h0);
    reset = 1'b0;
    tick();

    // ADD -> A, zero result with carry: z=1 s=0 c=1
    run_op("add", 0, 3'd0, 1'b0, 8'h00, 1'b1, 3, 1, 1'b0, 8'h00, 3'b101);
    // SHL -> D, 0x81 with carry in: s=1 z=0 c=0 (carry ignored)
    run_op("shl", 0, 3'd6, 1'b1, 8'h81, 1'b1, 3, 1, 1'b0, 8'h81, 3'b010);

    // NOP: done in cycle 1, nothing else moves
    drive(0, 1'b1, 3'd7, 1'b0, 8'h55, 1'b1);
    tick();
    drive(0, 1'b0, 3'd7, 1'b0, 8'h55, 1'b1);
    sample(0, en, la, ldd, bsy, dn, res, zsc);
    chk("nop done c1", 32'(dn), 32'h1);
    chk("nop busy c1", 32'(bsy), 32'h1);
    chk("nop en c1", 32'(en), 32'h0);
    chk("nop ld c1", 32'({la, ldd}), 32'h0);
    tick();
    sample(0, en, la, ldd, bsy, dn, res, zsc);
    chk("nop idle c2", 32'({bsy, dn}), 32'h0);
    chk("nop result", 32'(res), 32'h81);
    chk("nop zsc", 32'(zsc), 32'b010);

    // XOR with start held high: one op, next accepted right after DONE
    run_op("xor", 0, 3'd4, 1'b0, 8'h3C, 1'b1, 3, 1, 1'b1, 8'h00, 3'b000);
    sample(0, en, la, ldd, bsy, dn, res, zsc);
    chk("xor2 accepted busy", 32'(bsy), 32'h1);
    chk("xor2 accepted en", 32'(en), 32'(en_of(3'd4)));
    drive(0, 1'b0, 3'd4, 1'b0, 8'h3C, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    sample(0, en, la, ldd, bsy, dn, res, zsc);
    chk("xor2 idle", 32'({bsy, dn}), 32'h0);
    chk("xor result", 32'(res), 32'h3C);
    chk("xor zsc", 32'(zsc), 32'b000);

    // AND aborted by reset in SETTLE cycle 2
    drive(0, 1'b1, 3'd2, 1'b1, 8'hFF, 1'b1);
    tick();
    drive(0, 1'b0, 3'd2, 1'b1, 8'hFF, 1'b1);
    sample(0, en, la, ldd, bsy, dn, res, zsc);
    chk("and en c1", 32'(en), 32'(en_of(3'd2)));
    chk("and ld c1", 32'({la, ldd}), 32'h0);
    tick();
    sample(0, en, la, ldd, bsy, dn, res, zsc);
    chk("and ld c2", 32'({la, ldd}), 32'h0);
    reset = 1'b1;
    tick();
    sample(0, en, la, ldd, bsy, dn, res, zsc);
    chk("abort en", 32'(en), 32'h0);
    chk("abort ld", 32'({la, ldd}), 32'h0);
    chk("abort busy/done", 32'({bsy, dn}), 32'h0);
    chk("abort result", 32'(res), 32'h0);
    chk("abort zsc", 32'(zsc), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      sample(0, en, la, ldd, bsy, dn, res, zsc);
      chk($sformatf("post-abort ld c%0d", i), 32'({la, ldd, bsy}), 32'h0);
    end

    // Short instance: INC, LOAD in cycle 2, DONE in cycle 3
    run_op("inc1", 1, 3'd1, 1'b0, 8'h80, 1'b1, 1, 0, 1'b0, 8'h80, 3'b011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
